// File: rtl/header_flag_pipe_if.sv
// Valid/ready word bus; the master drives dat/vld and the slave answers with rdy.
interface header_flag_pipe_if #(
  parameter int W = 23
) ();
  logic [W-1:0] dat;
  logic         vld;
  logic         rdy;

  modport master (output dat, output vld, input rdy);
  modport slave  (input dat, input vld, output rdy);
endinterface

// File: rtl/header_flag_pipe.sv
// Inserts a service flag into each header (1-cycle registered latency); stalls input while the output word is held.
// Optional HFP_ERRMASK_EN: ErrorReq suppresses flagging; otherwise ErrorReq is ignored.
module header_flag_pipe #(
  parameter int                HDR_W    = 23,
  parameter int                INS_POS  = 11,
  parameter logic [HDR_W:0]    XOR_MASK = 24'h000088,
  parameter int                PEND_W   = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  header_flag_pipe_if.slave   i_hdr,
  header_flag_pipe_if.master  o_hdr,
  input  logic                i_serv_req,
  input  logic                i_error_req,
  output logic [PEND_W-1:0]   o_pend_cnt,
  output logic                o_pend_ovf
);

  if (INS_POS < 1 || INS_POS > HDR_W - 1) begin : g_bad_ins_pos
    $error("header_flag_pipe: INS_POS out of range 1..HDR_W-1");
  end

  // The flag bit itself is never inverted by the mask.
  localparam logic [HDR_W:0] INS_BIT      = {{HDR_W{1'b0}}, 1'b1} << INS_POS;
  localparam logic [HDR_W:0] XOR_MASK_EFF = XOR_MASK & ~INS_BIT;

  logic [HDR_W:0]    r_out_dat;
  logic              r_out_vld;
  logic [PEND_W-1:0] r_pend;
  logic              r_ovf;

  logic              w_hdr_rdy;
  logic              w_acc;
  logic              w_flag;
  logic              w_inc;
  logic              w_dec;
  logic [HDR_W:0]    w_word;
  logic [HDR_W:0]    w_word_out;

  assign w_hdr_rdy = !r_out_vld || o_hdr.rdy;
  assign w_acc     = i_hdr.vld && w_hdr_rdy;

  // Only requests already counted can flag a header; same-cycle ServReq waits.
`ifdef HFP_ERRMASK_EN
  assign w_flag = (r_pend != '0) && !i_error_req;
`else
  logic w_unused_err;
  assign w_flag       = (r_pend != '0);
  assign w_unused_err = i_error_req;
`endif

  assign w_inc      = i_serv_req;
  assign w_dec      = w_acc && w_flag;
  assign w_word     = {i_hdr.dat[HDR_W-1:INS_POS], w_flag, i_hdr.dat[INS_POS-1:0]};
  assign w_word_out = w_flag ? (w_word ^ XOR_MASK_EFF) : w_word;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else if (w_acc) begin
      r_out_vld <= 1'b1;
      r_out_dat <= w_word_out;
    end else if (o_hdr.rdy) begin
      r_out_vld <= 1'b0;
    end
  end

  // dec implies r_pend != 0, so the decrement cannot wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else if (w_inc && !w_dec) begin
      if (r_pend == '1) begin
        r_ovf <= 1'b1;
      end else begin
        r_pend <= r_pend + PEND_W'(1);
      end
    end else if (w_dec && !w_inc) begin
      r_pend <= r_pend - PEND_W'(1);
    end
  end

  assign i_hdr.rdy  = w_hdr_rdy;
  assign o_hdr.vld  = r_out_vld;
  assign o_hdr.dat  = r_out_dat;
  assign o_pend_cnt = r_pend;
  assign o_pend_ovf = r_ovf;

endmodule

// File: tb/tb_header_flag_pipe.sv
// Directed bench for header_flag_pipe: inputs change and outputs are checked on the falling edge.
module tb_header_flag_pipe;
  logic       clk;
  logic       rst;
  logic       serv;
  logic       err;
  logic [3:0] pend;
  logic       ovf;
  int         total;
  int         bad;

  header_flag_pipe_if #(.W(23)) hdr_if ();
  header_flag_pipe_if #(.W(24)) out_if ();

  header_flag_pipe dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_hdr       (hdr_if),
    .o_hdr       (out_if),
    .i_serv_req  (serv),
    .i_error_req (err),
    .o_pend_cnt  (pend),
    .o_pend_ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    total++; if (out_if.vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b want=0", out_if.vld); end
    total++; if (out_if.dat !== 24'h0) begin bad++; $display("FAIL rst_dat got=%h want=000000", out_if.dat); end
    total++; if (pend !== 4'd0) begin bad++; $display("FAIL rst_pend got=%0d want=0", pend); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", ovf); end
    rst = 1'b0;
    cyc();
    total++; if (hdr_if.rdy !== 1'b1) begin bad++; $display("FAIL rst_rdy got=%b want=1", hdr_if.rdy); end
  endtask

  task automatic test_plain();
    hdr_if.dat = 23'h7FFFFF;
    hdr_if.vld = 1'b1;
    cyc();
    total++; if (out_if.vld !== 1'b1) begin bad++; $display("FAIL plain_vld got=%b want=1", out_if.vld); end
    total++; if (out_if.dat !== 24'hFFF7FF) begin bad++; $display("FAIL plain_dat got=%h want=fff7ff", out_if.dat); end
    total++; if (pend !== 4'd0) begin bad++; $display("FAIL plain_pend got=%0d want=0", pend); end
    hdr_if.vld = 1'b0;
    cyc();
    total++; if (out_if.vld !== 1'b0) begin bad++; $display("FAIL plain_drain got=%b want=0", out_if.vld); end
  endtask

  task automatic test_flag();
    serv = 1'b1;
    cyc();
    serv = 1'b0;
    total++; if (pend !== 4'd1) begin bad++; $display("FAIL flag_pend1 got=%0d want=1", pend); end
    hdr_if.dat = 23'h000000;
    hdr_if.vld = 1'b1;
    cyc();
    hdr_if.vld = 1'b0;
    total++; if (out_if.dat !== 24'h000888) begin bad++; $display("FAIL flag_dat got=%h want=000888", out_if.dat); end
    total++; if (pend !== 4'd0) begin bad++; $display("FAIL flag_pend0 got=%0d want=0", pend); end
  endtask

  task automatic test_errmask();
    serv = 1'b1;
    cyc();
    serv = 1'b0;
    err = 1'b1;
    hdr_if.dat = 23'h000000;
    hdr_if.vld = 1'b1;
    cyc();
`ifdef HFP_ERRMASK_EN
    total++; if (out_if.dat !== 24'h000000) begin bad++; $display("FAIL err_dat got=%h want=000000", out_if.dat); end
    total++; if (pend !== 4'd1) begin bad++; $display("FAIL err_pend got=%0d want=1", pend); end
`else
    total++; if (out_if.dat !== 24'h000888) begin bad++; $display("FAIL err_dat got=%h want=000888", out_if.dat); end
    total++; if (pend !== 4'd0) begin bad++; $display("FAIL err_pend got=%0d want=0", pend); end
`endif
    err = 1'b0;
    cyc();
    hdr_if.vld = 1'b0;
`ifdef HFP_ERRMASK_EN
    total++; if (out_if.dat !== 24'h000888) begin bad++; $display("FAIL err_after_dat got=%h want=000888", out_if.dat); end
`else
    total++; if (out_if.dat !== 24'h000000) begin bad++; $display("FAIL err_after_dat got=%h want=000000", out_if.dat); end
`endif
    total++; if (pend !== 4'd0) begin bad++; $display("FAIL err_after_pend got=%0d want=0", pend); end
  endtask

  task automatic test_simultaneous();
    serv = 1'b1;
    cyc();
    cyc();
    total++; if (pend !== 4'd2) begin bad++; $display("FAIL sim_pend_pre got=%0d want=2", pend); end
    hdr_if.dat = 23'h555555;
    hdr_if.vld = 1'b1;
    cyc();
    serv = 1'b0;
    hdr_if.vld = 1'b0;
    total++; if (pend !== 4'd2) begin bad++; $display("FAIL sim_pend got=%0d want=2", pend); end
    total++; if (out_if.dat !== 24'hAAADDD) begin bad++; $display("FAIL sim_dat got=%h want=aaaddd", out_if.dat); end
    cyc();
  endtask

  task automatic test_back_to_back();
    hdr_if.dat = 23'h000000;
    hdr_if.vld = 1'b1;
    cyc();
    total++; if (out_if.dat !== 24'h000888) begin bad++; $display("FAIL b2b_dat0 got=%h want=000888", out_if.dat); end
    total++; if (pend !== 4'd1) begin bad++; $display("FAIL b2b_pend0 got=%0d want=1", pend); end
    cyc();
    total++; if (pend !== 4'd0) begin bad++; $display("FAIL b2b_pend1 got=%0d want=0", pend); end
    total++; if (out_if.vld !== 1'b1) begin bad++; $display("FAIL b2b_vld1 got=%b want=1", out_if.vld); end
    hdr_if.dat = 23'h555555;
    cyc();
    hdr_if.vld = 1'b0;
    total++; if (out_if.dat !== 24'hAAA555) begin bad++; $display("FAIL b2b_dat2 got=%h want=aaa555", out_if.dat); end
    cyc();
  endtask

  task automatic test_saturation();
    serv = 1'b1;
    for (int i = 0; i < 15; i++) cyc();
    total++; if (pend !== 4'd15) begin bad++; $display("FAIL sat_pend15 got=%0d want=15", pend); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL sat_ovf_early got=%b want=0", ovf); end
    cyc();
    serv = 1'b0;
    total++; if (pend !== 4'd15) begin bad++; $display("FAIL sat_pend16 got=%0d want=15", pend); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b want=1", ovf); end
    hdr_if.dat = 23'h000000;
    hdr_if.vld = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc();
      total++;
      if (out_if.dat !== 24'h000888 || pend !== 4'(14 - i)) begin
        bad++;
        $display("FAIL drain_%0d got dat=%h pend=%0d want dat=000888 pend=%0d", i, out_if.dat, pend, 14 - i);
      end
    end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL drain_ovf got=%b want=1", ovf); end
    cyc();
    hdr_if.vld = 1'b0;
    total++; if (out_if.dat !== 24'h000000) begin bad++; $display("FAIL drain_empty got=%h want=000000", out_if.dat); end
    cyc();
  endtask

  task automatic test_backpressure_reset();
    hdr_if.dat = 23'h123456;
    hdr_if.vld = 1'b1;
    cyc();
    out_if.rdy = 1'b0;
    hdr_if.dat = 23'h000000;
    serv = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      total++;
      if (hdr_if.rdy !== 1'b0 || out_if.vld !== 1'b1 || out_if.dat !== 24'h246456 || pend !== 4'(i)) begin
        bad++;
        $display("FAIL bp_%0d got rdy=%b vld=%b dat=%h pend=%0d want rdy=0 vld=1 dat=246456 pend=%0d",
                 i, hdr_if.rdy, out_if.vld, out_if.dat, pend, i);
      end
    end
    rst = 1'b1;
    cyc();
    total++; if (out_if.vld !== 1'b0) begin bad++; $display("FAIL bprst_vld got=%b want=0", out_if.vld); end
    total++; if (out_if.dat !== 24'h0) begin bad++; $display("FAIL bprst_dat got=%h want=000000", out_if.dat); end
    total++; if (pend !== 4'd0) begin bad++; $display("FAIL bprst_pend got=%0d want=0", pend); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL bprst_ovf got=%b want=0", ovf); end
    rst = 1'b0;
    serv = 1'b0;
    hdr_if.vld = 1'b0;
    out_if.rdy = 1'b1;
    cyc();
    total++; if (hdr_if.rdy !== 1'b1) begin bad++; $display("FAIL bprst_rdy got=%b want=1", hdr_if.rdy); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    serv = 1'b0;
    err = 1'b0;
    hdr_if.dat = '0;
    hdr_if.vld = 1'b0;
    out_if.rdy = 1'b1;
    test_reset();
    test_plain();
    test_flag();
    test_errmask();
    test_simultaneous();
    test_back_to_back();
    test_saturation();
    test_backpressure_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
